// File: rtl/fp_divider_if.sv
// Handshake and operand/result bundle between an FPU issue slot and fp_divider.
interface fp_divider_if;
    logic        start;
    logic [31:0] FP1;
    logic [31:0] FP2;
    logic [31:0] result;
    logic        ovf;
    logic        dz;
    logic        busy;
    logic        done;

    modport master (output start, FP1, FP2, input result, ovf, dz, busy, done);
    modport slave  (input start, FP1, FP2, output result, ovf, dz, busy, done);
endinterface

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division, one quotient bit per clock.
// Define FPDIV_ROUND_EN for round-to-nearest-even (one extra quotient bit, one extra cycle); default truncates.
module fp_divider #(
    parameter int BIAS = 127
) (
    input  logic         clk,
    input  logic         reset,
    fp_divider_if.slave  bus
);

`ifdef FPDIV_ROUND_EN
    localparam int QB = 26;
`else
    localparam int QB = 25;
`endif

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t              state_reg, state_next;
    logic [4:0]          count_reg;
    logic [31:0]         a_reg, b_reg;
    logic [25:0]         r_reg;
    logic [QB-1:0]       q_reg;
    logic [31:0]         result_reg;
    logic                ovf_reg, dz_reg;
    logic                busy, done;

    logic [25:0]         mb_ext, diff;
    logic                q_bit;

    logic                sign, a_zero, b_zero;
    logic signed [9:0]   e_diff, e_norm, e_fin;
    logic [22:0]         mant, mant_fin;
    logic [31:0]         result_next;
    logic                ovf_next, dz_next;
`ifdef FPDIV_ROUND_EN
    logic                g, st;
    logic [23:0]         mant_inc;
`endif

    assign mb_ext = {2'b00, 1'b1, b_reg[22:0]};
    assign q_bit  = (r_reg >= mb_ext);
    assign diff   = r_reg - mb_ext;

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = DIV;
            DIV:     if (count_reg == 5'(QB - 1)) state_next = NORM;
            NORM:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end

    // Datapath: operand capture, quotient iterations, result publication
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            r_reg      <= '0;
            q_reg      <= '0;
            count_reg  <= '0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            dz_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.FP1;
                        b_reg     <= bus.FP2;
                        r_reg     <= {2'b00, 1'b1, bus.FP1[22:0]};
                        q_reg     <= '0;
                        count_reg <= '0;
                        ovf_reg   <= 1'b0;
                        dz_reg    <= 1'b0;
                    end
                end
                DIV: begin
                    // r stays below 2*mb, so the shift never loses a set bit
                    q_reg     <= {q_reg[QB-2:0], q_bit};
                    r_reg     <= (q_bit ? diff : r_reg) << 1;
                    count_reg <= count_reg + 5'd1;
                end
                NORM: begin
                    result_reg <= result_next;
                    ovf_reg    <= ovf_next;
                    dz_reg     <= dz_next;
                end
                default: ;
            endcase
        end
    end

    assign sign   = a_reg[31] ^ b_reg[31];
    assign a_zero = (a_reg[30:23] == 8'd0);
    assign b_zero = (b_reg[30:23] == 8'd0);
    assign e_diff = {2'b00, a_reg[30:23]} - {2'b00, b_reg[30:23]} + 10'(BIAS);

    // Normalise, optionally round, then apply special cases in priority order
    always_comb begin
        if (q_reg[QB-1]) begin
            mant   = q_reg[QB-2:QB-24];
            e_norm = e_diff;
        end else begin
            mant   = q_reg[QB-3:QB-25];
            e_norm = e_diff - 10'sd1;
        end

        mant_fin = mant;
        e_fin    = e_norm;
`ifdef FPDIV_ROUND_EN
        g        = q_reg[QB-1] ? q_reg[1] : q_reg[0];
        st       = (r_reg != 26'd0) | (q_reg[QB-1] & q_reg[0]);
        mant_inc = {1'b0, mant} + 24'd1;
        if (g & (st | mant[0])) begin
            if (mant_inc[23]) begin
                mant_fin = 23'd0;
                e_fin    = e_norm + 10'sd1;
            end else begin
                mant_fin = mant_inc[22:0];
            end
        end
`endif

        result_next = {sign, e_fin[7:0], mant_fin};
        ovf_next    = 1'b0;
        dz_next     = 1'b0;
        if (a_zero && b_zero) begin
            result_next = 32'h7FC0_0000;
            dz_next     = 1'b1;
        end else if (b_zero) begin
            result_next = {sign, 8'hFF, 23'd0};
            dz_next     = 1'b1;
        end else if (a_zero) begin
            result_next = {sign, 31'd0};
        end else if (e_fin >= 10'sd255) begin
            result_next = {sign, 8'hFF, 23'd0};
            ovf_next    = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            result_next = {sign, 31'd0};
        end
    end

    assign bus.result = result_reg;
    assign bus.ovf    = ovf_reg;
    assign bus.dz     = dz_reg;
    assign bus.busy   = busy;
    assign bus.done   = done;

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed cases, randomized operands against an arithmetic reference.
module tb_fp_divider;

`ifdef FPDIV_ROUND_EN
    localparam int QB = 26;
    localparam bit ROUND = 1'b1;
    localparam logic [31:0] THIRD = 32'h3EAA_AAAB;
`else
    localparam int QB = 25;
    localparam bit ROUND = 1'b0;
    localparam logic [31:0] THIRD = 32'h3EAA_AAAA;
`endif

    logic clk = 1'b0;
    logic reset;

    fp_divider_if dif ();

    fp_divider #(.BIAS(127)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nfail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact integer quotient of the scaled mantissas, then IEEE field assembly.
    // Returns {ovf, dz, result}.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, low;
        longint unsigned ma, mb, num, qv, rem, lowbits;
        logic [22:0] mant;
        logic g, st;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 && eb == 0) return {2'b01, 32'h7FC0_0000};
        if (eb == 0) return {2'b01, s, 8'hFF, 23'h0};
        if (ea == 0) return {2'b00, s, 31'h0};
        ma  = 64'h80_0000 | 64'(a[22:0]);
        mb  = 64'h80_0000 | 64'(b[22:0]);
        num = ma << (QB - 1);
        qv  = num / mb;
        rem = num % mb;
        e   = ea - eb + 127;
        if (qv >= (64'd1 << (QB - 1))) low = QB - 24;
        else begin
            low = QB - 25;
            e   = e - 1;
        end
        mant = 23'(qv >> low);
        if (ROUND && low > 0) begin
            g       = qv[low-1];
            lowbits = qv & ((64'd1 << (low - 1)) - 64'd1);
            st      = (rem != 0) || (lowbits != 0);
            if (g && (st || mant[0])) begin
                if (mant == 23'h7F_FFFF) begin
                    mant = 23'h0;
                    e    = e + 1;
                end else begin
                    mant = mant + 23'd1;
                end
            end
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
        if (e <= 0) return {2'b00, s, 31'h0};
        return {2'b00, s, 8'(e), mant};
    endfunction

    // Starts at a negedge in IDLE, ends at a negedge back in IDLE.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic eo, input logic ed);
        int n;
        bit seen;
        dif.start = 1'b1;
        dif.FP1   = a;
        dif.FP2   = b;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        check({tag, "_busy"}, 32'(dif.busy), 32'd1);
        n = 1;
        seen = 1'b0;
        while (n < QB + 40 && !seen) begin
            if (dif.done) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_latency"}, 32'(n - 1), 32'(QB + 1));
            check({tag, "_result"}, dif.result, er);
            check({tag, "_ovf"}, 32'(dif.ovf), 32'(eo));
            check({tag, "_dz"}, 32'(dif.dz), 32'(ed));
            $display("op %s: %h / %h -> %h ovf=%b dz=%b", tag, a, b, dif.result, dif.ovf, dif.dz);
            @(negedge clk);
            check({tag, "_done_pulse"}, 32'(dif.done), 32'd0);
            check({tag, "_idle"}, 32'(dif.busy), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [33:0] m;
        logic [31:0] held_a, held_b, held_res;
        int ndone, n;
        bit prev_done, seen;

        reset     = 1'b1;
        dif.start = 1'b0;
        dif.FP1   = '0;
        dif.FP2   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", dif.result, 32'h0);
        check("rst_ovf", 32'(dif.ovf), 32'd0);
        check("rst_dz", 32'(dif.dz), 32'd0);
        check("rst_busy", 32'(dif.busy), 32'd0);
        check("rst_done", 32'(dif.done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op("six_div_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
        do_op("one_third",   32'h3F80_0000, 32'h4040_0000, THIRD,         1'b0, 1'b0);
        do_op("neg_div",     32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 1'b0, 1'b0);
        do_op("div_zero",    32'hC000_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0, 1'b1);
        do_op("zero_zero",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b1);
        do_op("overflow",    32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b1, 1'b0);
        do_op("underflow",   32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b0);
        do_op("zero_num",    32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            if (i < 16) begin
                ra = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
                rb = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
            end else begin
                ra = $urandom;
                rb = $urandom;
            end
            m = model(ra, rb);
            do_op($sformatf("rand%0d", i), ra, rb, m[31:0], m[33], m[32]);
        end

        // start held high with operands changing after the accepting edge
        held_a = 32'h4110_0000;
        held_b = 32'h4040_0000;
        dif.start = 1'b1;
        dif.FP1   = held_a;
        dif.FP2   = held_b;
        @(posedge clk);
        ndone     = 0;
        prev_done = 1'b0;
        held_res  = 32'h0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (prev_done) check("held_idle_gap", 32'(dif.busy), 32'd0);
            if (dif.done) begin
                ndone++;
                held_res = dif.result;
            end
            prev_done = dif.done;
            dif.FP1   = $urandom;
            dif.FP2   = $urandom;
        end
        m = model(held_a, held_b);
        check("held_done_count", 32'(ndone), 32'd1);
        check("held_result", held_res, m[31:0]);
        $display("op held_start: %h / %h -> %h done_pulses=%0d", held_a, held_b, held_res, ndone);
        dif.start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < QB + 40 && !seen) begin
            @(negedge clk);
            n++;
            if (dif.done) seen = 1'b1;
        end
        if (!seen) check("held_second_timeout", 32'd0, 32'd1);
        @(negedge clk);

        // reset at E10 of an operation aborts it
        do_op("pre_reset", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
        dif.start = 1'b1;
        dif.FP1   = 32'hC000_0000;
        dif.FP2   = 32'h0000_0000;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_result", dif.result, 32'h0);
        check("abort_ovf", 32'(dif.ovf), 32'd0);
        check("abort_dz", 32'(dif.dz), 32'd0);
        check("abort_busy", 32'(dif.busy), 32'd0);
        check("abort_done", 32'(dif.done), 32'd0);
        $display("op abort: reset at E10, result=%h busy=%b", dif.result, dif.busy);
        reset = 1'b0;
        @(negedge clk);
        do_op("post_reset", 32'h3F80_0000, 32'h4040_0000, THIRD, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule
